// File: rtl/fir_pkg.sv
// Shared FSM state encoding and width helpers for the sequential FIR MAC.
package fir_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StClear = 2'd0;
  localparam state_t StIdle  = 2'd1;
  localparam state_t StMac   = 2'd2;
  localparam state_t StOut   = 2'd3;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int width;
    width = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

  // Index width for a TAPS-deep storage, never narrower than one bit.
  function automatic int addr_width(input int taps);
    return (clog2(taps) < 1) ? 1 : clog2(taps);
  endfunction

  // Accumulator width that cannot overflow over TAPS full-precision products.
  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + clog2(taps);
  endfunction

endpackage

// File: rtl/fir_ring_ram.sv
// Single-port sample ring with a registered read port.
module fir_ring_ram #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // One access per cycle: either a write or a registered read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/fir_mac_seq.sv
// Sequential FIR filter: one multiply-accumulate per cycle over a sample ring.
module fir_mac_seq
  import fir_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int COEF_W = 16,
  parameter int TAPS   = 223,
  parameter int OUT_W  = 10,
  parameter int SHIFT  = 17
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        s_valid_in,
  output logic                        s_ready_out,
  input  logic signed [DATA_W-1:0]    s_data_in,
  output logic                        m_valid_out,
  input  logic                        m_ready_in,
  output logic signed [OUT_W-1:0]     m_data_out,
  input  logic                        coef_we_in,
  input  logic [addr_width(TAPS)-1:0] coef_addr_in,
  input  logic signed [COEF_W-1:0]    coef_data_in,
  output logic                        coef_err_out,
  output logic                        busy_out
);

  localparam int AW    = addr_width(TAPS);
  localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
  localparam int CW    = clog2(TAPS + 1);
  localparam int PW    = DATA_W + COEF_W;

  localparam int RndShift = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_W:0] RndTerm =
      (SHIFT > 0) ? ((ACC_W + 1)'(1) <<< RndShift) : (ACC_W + 1)'(0);
  localparam logic signed [ACC_W:0] OutMax = (ACC_W + 1)'((longint'(1) <<< (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] OutMin = -OutMax - (ACC_W + 1)'(1);

  state_t                    state_q;
  logic [AW-1:0]             clr_cnt_q;
  logic [AW-1:0]             wr_ptr_q;
  logic [AW-1:0]             rd_ptr_q;
  logic [CW-1:0]             tap_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [COEF_W-1:0]  coef_rd_q;
  logic                      err_q;
  logic signed [COEF_W-1:0]  coef_mem [TAPS];

  logic                      accept;
  logic                      coef_wr;
  logic                      ram_we;
  logic [AW-1:0]             ram_addr;
  logic [DATA_W-1:0]         ram_wdata;
  logic [DATA_W-1:0]         ram_rdata;
  logic signed [PW-1:0]      prod;
  logic [AW-1:0]             rd_ptr_prev;
  logic [AW-1:0]             wr_ptr_next;
  logic signed [ACC_W:0]     rounded;
  logic signed [ACC_W:0]     shifted;
  logic signed [OUT_W-1:0]   sat;

  // Handshake and status outputs; reset overrides whatever state is held.
  always_comb begin
    s_ready_out  = (state_q == StIdle) && !rst_in;
    m_valid_out  = (state_q == StOut) && !rst_in;
    busy_out     = rst_in || (state_q != StIdle);
    coef_err_out = err_q && !rst_in;
    accept       = s_ready_out && s_valid_in;
    coef_wr      = coef_we_in && s_ready_out && (int'(coef_addr_in) < TAPS);
    m_data_out   = rst_in ? '0 : sat;
  end

  // Ring port arbitration: clear walk, sample write, or tap read.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = rd_ptr_q;
    ram_wdata = '0;
    unique case (state_q)
      StClear: begin
        ram_we   = 1'b1;
        ram_addr = clr_cnt_q;
      end
      StIdle: begin
        ram_we    = accept;
        ram_addr  = wr_ptr_q;
        ram_wdata = s_data_in;
      end
      default: ram_addr = rd_ptr_q;
    endcase
  end

  // Pointer wrap arithmetic and the full-precision product.
  always_comb begin
    rd_ptr_prev = (rd_ptr_q == '0) ? AW'(TAPS - 1) : rd_ptr_q - 1'b1;
    wr_ptr_next = (wr_ptr_q == AW'(TAPS - 1)) ? '0 : wr_ptr_q + 1'b1;
    prod        = PW'($signed(ram_rdata)) * PW'(coef_rd_q);
  end

  // Round half up, arithmetic shift, then clamp to the output range.
  always_comb begin
    rounded = $signed({acc_q[ACC_W-1], acc_q}) + RndTerm;
    shifted = rounded >>> SHIFT;
    if (shifted > OutMax) begin
      sat = {1'b0, {(OUT_W - 1){1'b1}}};
    end else if (shifted < OutMin) begin
      sat = {1'b1, {(OUT_W - 1){1'b0}}};
    end else begin
      sat = shifted[OUT_W-1:0];
    end
  end

  // Coefficient store: zeroed by the clear walk, otherwise written only in IDLE.
  always_ff @(posedge clk_in) begin
    if (state_q == StClear) begin
      coef_mem[clr_cnt_q] <= '0;
    end else if (coef_wr) begin
      coef_mem[coef_addr_in] <= coef_data_in;
    end
  end

  // Main FSM. MAC runs TAPS+1 cycles: tap reads are pipelined one cycle ahead of the accumulate.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= StClear;
      clr_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tap_q     <= '0;
      acc_q     <= '0;
      coef_rd_q <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= coef_we_in && (state_q != StIdle);
      unique case (state_q)
        StClear: begin
          if (clr_cnt_q == AW'(TAPS - 1)) begin
            clr_cnt_q <= '0;
            state_q   <= StIdle;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        StIdle: begin
          if (accept) begin
            acc_q    <= '0;
            tap_q    <= '0;
            rd_ptr_q <= wr_ptr_q;
            state_q  <= StMac;
          end
        end
        StMac: begin
          tap_q <= tap_q + 1'b1;
          if (tap_q < CW'(TAPS)) begin
            coef_rd_q <= coef_mem[tap_q[AW-1:0]];
            rd_ptr_q  <= rd_ptr_prev;
          end
          if (tap_q != '0) begin
            acc_q <= acc_q + ACC_W'(prod);
          end
          if (tap_q == CW'(TAPS)) begin
            wr_ptr_q <= wr_ptr_next;
            state_q  <= StOut;
          end
        end
        StOut: begin
          if (m_ready_in) state_q <= StIdle;
        end
        default: state_q <= StClear;
      endcase
    end
  end

  fir_ring_ram #(
    .DEPTH (TAPS),
    .WIDTH (DATA_W),
    .AW    (AW)
  ) u_ring (
    .clk   (clk_in),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: doc/fir_mac_seq.md
FIR_MAC_SEQ -- requirements
Module: fir_mac_seq

Interface
REQ-001 Parameter DATA_W, default 10: signed input sample width.
REQ-002 Parameter COEF_W, default 16: signed coefficient width.
REQ-003 Parameter TAPS, default 223: filter length, range 2..1024.
REQ-004 Parameter OUT_W, default 10: signed output width.
REQ-005 Parameter SHIFT, default 17: arithmetic right shift applied to the accumulator before output.
REQ-006 Derived ACC_W = DATA_W + COEF_W + clog2(TAPS); AW = clog2(TAPS).
REQ-007 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-008 clk_in  in  1  sole clock, rising edge.
REQ-009 rst_in  in  1  synchronous active-high reset.
REQ-010 s_valid_in  in  1  input sample valid.
REQ-011 s_ready_out  out  1  block can accept a sample.
REQ-012 s_data_in  in  DATA_W  signed input sample.
REQ-013 m_valid_out  out  1  output sample valid.
REQ-014 m_ready_in  in  1  consumer accepts the output.
REQ-015 m_data_out  out  OUT_W  signed filtered sample.
REQ-016 coef_we_in  in  1  coefficient write strobe.
REQ-017 coef_addr_in  in  AW  coefficient index k.
REQ-018 coef_data_in  in  COEF_W  signed coefficient h[k].
REQ-019 coef_err_out  out  1  one-cycle pulse when a coefficient write is dropped.
REQ-020 busy_out  out  1  high in every state except IDLE.

Function
REQ-021 FSM states: CLEAR, IDLE, MAC, OUT.
- CLEAR: walks addresses 0..TAPS-1, one per cycle, zeroing the sample ring and the coefficients.
- CLEAR exits to IDLE after TAPS cycles.
REQ-022 s_ready_out is high only in IDLE. A sample is accepted when s_valid_in and s_ready_out are both high.
REQ-023 On acceptance:
- The sample is written to the ring at wr_ptr.
- The accumulator is cleared.
- The FSM enters MAC.
REQ-024 MAC performs one multiply-accumulate per cycle, for k = 0..TAPS-1: acc += x[(wr_ptr - k) mod TAPS] * h[k], with full-precision signed arithmetic in ACC_W bits.
REQ-025 After the last tap, wr_ptr advances (wrapping from TAPS-1 to 0) and the FSM enters OUT.
REQ-026 m_data_out = saturate_OUT_W((acc + 2^(SHIFT-1)) >>> SHIFT), i.e. round half up. When SHIFT = 0, no rounding term is added.
REQ-027 Saturation clamps to +(2^(OUT_W-1) - 1) or -2^(OUT_W-1).
REQ-028 m_valid_out is high only in OUT. m_data_out stays stable while m_valid_out is high and m_ready_in is low.
REQ-029 When m_valid_out and m_ready_in are both high, the FSM returns to IDLE the next cycle. s_ready_out rises in that same cycle.
REQ-030 Latency from the acceptance edge to m_valid_out high is exactly TAPS+1 cycles.
REQ-031 Coefficient writes are performed only in IDLE.
- A write in any other state is dropped and coef_err_out pulses for one cycle.
- When a write and a sample acceptance occur in the same IDLE cycle, the write completes first and the MAC uses the new coefficient.

Reset
REQ-032 While rst_in is high, the block holds these values:
- s_ready_out = 0, m_valid_out = 0, m_data_out = 0, coef_err_out = 0, busy_out = 1.
- wr_ptr = 0, acc = 0.
- FSM = CLEAR.
REQ-033 Reset asserted in any state, including mid-MAC or mid-OUT, aborts the current operation and discards the pending output. The FSM then re-enters CLEAR from address 0.
REQ-034 After rst_in falls, IDLE is reached after TAPS cycles.

Structure
REQ-035 Package fir_pkg holds the FSM state enum and the clog2-based width helper functions.
REQ-036 Sub-module fir_ring_ram: a single-port sample ring of TAPS x DATA_W, instantiated once. Coefficient storage is a separate TAPS x COEF_W array.

Verification
REQ-037 Impulse response. Setup: TAPS=8, h = 1..8, SHIFT=0, OUT_W=16. Stimulus: input 1, then 7 zeros. Required: outputs 1, 2, ..., 8; a further zero input gives 0.
REQ-038 Rounding. Setup: SHIFT=2, TAPS=2, h = {1, 0}. Stimulus: inputs 6 and -6. Required: outputs 2 and -1.
REQ-039 Saturation. Setup: DATA_W=10, COEF_W=16, all h = 32767, SHIFT=0, OUT_W=10. Stimulus: input 511. Required: output 511; input -512 gives -512.
REQ-040 Backpressure. Stimulus: m_ready_in held low for 5 cycles in OUT. Required: m_data_out stable, s_ready_out stays 0, and the next sample is accepted only after the handshake.
REQ-041 Dropped write. Stimulus: coef_we_in pulsed during MAC. Required: coef_err_out pulses once, the coefficient is unchanged, and the output matches the model.
REQ-042 Mid-MAC reset. Stimulus: rst_in pulsed at tap 3. Required: no m_valid_out, s_ready_out returns high exactly TAPS cycles after rst_in falls, and the next impulse gives all-zero output until coefficients are reloaded.
